// File: rtl/qif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// qif_neuron_scheduler
//
// Time-multiplexed controller for one shared quadratic integrate-and-fire
// membrane datapath serving N_NEU virtual neurons. Each timestep sweep visits
// neurons 0..N_NEU-1 in order. For each neuron it:
//   1. fetches the input current over a req/valid handshake,
//   2. applies the two-regime membrane update,
//   3. emits a spike event over a valid/ready handshake when the membrane
//      overflows.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   step_start          1-cycle pulse that starts a sweep (only honoured in IDLE)
//   busy                high for the whole sweep
//   step_done           1-cycle pulse after the last neuron has retired
//   Vpde_thres          regime-select threshold (m <= Vpde_thres -> a regime)
//   Vthres, Vrest       upper / lower regime reference voltages
//   Vreset              reset / post-spike membrane value
//   a, b                lower / upper regime gains
//   in_req, in_idx      input current request and neuron index
//   in_valid, in_data   input current response (sampled only while requesting)
//   spk_valid, spk_idx  spike event and its neuron index
//   spk_ready           downstream accept for the spike event
//   dbg_idx, dbg_mem    combinational membrane read port
// -----------------------------------------------------------------------------
module qif_neuron_scheduler #(
    parameter int N_NEU = 16,
    parameter int IDX_W = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_start,
    output logic             busy,
    output logic             step_done,
    input  logic [7:0]       Vpde_thres,
    input  logic [7:0]       Vthres,
    input  logic [7:0]       Vrest,
    input  logic [7:0]       Vreset,
    input  logic [2:0]       a,
    input  logic [2:0]       b,
    output logic             in_req,
    output logic [IDX_W-1:0] in_idx,
    input  logic             in_valid,
    input  logic [8:0]       in_data,
    output logic             spk_valid,
    input  logic             spk_ready,
    output logic [IDX_W-1:0] spk_idx,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [7:0]       dbg_mem
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_UPD  = 3'd2,
        S_EMIT = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEU - 1);

    // Two-regime QIF update. Returns {ovf, sol}: ovf set means the 9-bit sum
    // m + t carried out, i.e. the neuron spikes. All arithmetic is modulo 256
    // except the final carry, so only the low byte of the product matters.
    function automatic logic [8:0] qif_update(
        input logic [7:0] m,
        input logic [7:0] cur,
        input logic [7:0] pde,
        input logic [7:0] thr,
        input logic [7:0] rest,
        input logic [2:0] ga,
        input logic [2:0] gb
    );
        logic [7:0]  diff;
        logic [10:0] prod;
        logic [7:0]  t;
        if (m <= pde) begin
            diff = rest - m;
            prod = {8'd0, ga} * {3'd0, diff};
        end else begin
            diff = m - thr;
            prod = {8'd0, gb} * {3'd0, diff};
        end
        t = cur + prod[7:0];
        return {1'b0, m} + {1'b0, t};
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    // Only the low byte of the input current survives the modulo-256 update,
    // so bit 8 is not stored.
    logic [7:0]       cur_q, cur_d;
    logic [7:0]       mem_q [N_NEU];
    logic [8:0]       upd_s;
    logic             busy_q, step_done_q, in_req_q, spk_valid_q;
    logic [IDX_W-1:0] in_idx_q, spk_idx_q;

    assign busy      = busy_q;
    assign step_done = step_done_q;
    assign in_req    = in_req_q;
    assign in_idx    = in_idx_q;
    assign spk_valid = spk_valid_q;
    assign spk_idx   = spk_idx_q;

    // Membrane update result for the neuron currently addressed by cnt_q.
    always_comb begin
        upd_s = qif_update(mem_q[cnt_q], cur_q, Vpde_thres, Vthres, Vrest, a, b);
    end

    // Debug read; addresses beyond the neuron count read as zero.
    always_comb begin
        if (int'(dbg_idx) < N_NEU) begin
            dbg_mem = mem_q[dbg_idx];
        end else begin
            dbg_mem = 8'd0;
        end
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        case (state_q)
            S_IDLE: begin
                if (step_start) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (in_valid) begin
                    cur_d   = in_data[7:0];
                    state_d = S_UPD;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_UPD: begin
                if (upd_s[8]) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_EMIT: begin
                if (spk_ready) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_NEXT: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, membrane array and registered outputs. Outputs are decoded from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_q       <= 8'd0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            in_req_q    <= 1'b0;
            in_idx_q    <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            for (int i = 0; i < N_NEU; i++) begin
                mem_q[i] <= Vreset;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            busy_q      <= (state_d != S_IDLE);
            step_done_q <= (state_d == S_DONE);
            in_req_q    <= (state_d == S_REQ);
            in_idx_q    <= cnt_d;
            spk_valid_q <= (state_d == S_EMIT);
            spk_idx_q   <= cnt_d;
            if (state_q == S_UPD) begin
                if (upd_s[8]) begin
                    mem_q[cnt_q] <= Vreset;
                end else begin
                    mem_q[cnt_q] <= upd_s[7:0];
                end
            end else begin
                mem_q[cnt_q] <= mem_q[cnt_q];
            end
        end
    end

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// tb_qif_neuron_scheduler
//
// Self-checking bench for qif_neuron_scheduler with four virtual neurons.
// A table of configuration vectors is swept one at a time; an upstream
// responder supplies input currents, a reference model predicts membranes and
// queues expected spike indices, which are popped as the DUT hands spikes off.
// Hand-written sequences cover multi-sweep backpressure and mid-sweep reset.
// -----------------------------------------------------------------------------
module tb_qif_neuron_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          step_start;
    logic          busy;
    logic          step_done;
    logic [7:0]    Vpde_thres, Vthres, Vrest, Vreset;
    logic [2:0]    a, b;
    logic          in_req;
    logic [IW-1:0] in_idx;
    logic          in_valid;
    logic [8:0]    in_data;
    logic          spk_valid;
    logic          spk_ready;
    logic [IW-1:0] spk_idx;
    logic [IW-1:0] dbg_idx;
    logic [7:0]    dbg_mem;

    always #5 clk = ~clk;

    qif_neuron_scheduler #(.N_NEU(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .step_start(step_start), .busy(busy),
        .step_done(step_done), .Vpde_thres(Vpde_thres), .Vthres(Vthres),
        .Vrest(Vrest), .Vreset(Vreset), .a(a), .b(b), .in_req(in_req),
        .in_idx(in_idx), .in_valid(in_valid), .in_data(in_data),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx),
        .dbg_idx(dbg_idx), .dbg_mem(dbg_mem)
    );

    int n_cmp = 0;
    int n_err = 0;
    int model_mem [N];
    int bench_data [N];
    int spk_q [$];

    typedef struct {
        int vreset; int vpde; int vthres; int vrest; int ga; int gb;
        int idata; int rdy_delay; int exp_mem; int exp_spk;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference QIF update from the arithmetic definition, in integer math.
    function automatic void model_update(input int idx, input int cur);
        int m, x, t, s;
        m = model_mem[idx];
        if (m <= int'(Vpde_thres)) x = cur + int'(a) * (int'(Vrest) - m);
        else                       x = cur + int'(b) * (m - int'(Vthres));
        t = ((x % 256) + 256) % 256;
        s = m + t;
        if (s > 255) begin
            model_mem[idx] = int'(Vreset);
            spk_q.push_back(idx);
        end else begin
            model_mem[idx] = s;
        end
    endfunction

    task automatic do_reset(input int vr);
        Vreset = 8'(vr);
        in_valid = 1'b0; spk_ready = 1'b0; step_start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) model_mem[i] = vr;
        spk_q.delete();
    endtask

    task automatic check_mems(input string nm);
        for (int i = 0; i < N; i++) begin
            dbg_idx = IW'(i);
            #1;
            chk(nm, int'(dbg_mem), model_mem[i]);
        end
    endtask

    // One sweep: responds to requests, applies spike backpressure, optionally
    // pokes step_start mid-sweep. Returns negedge count to step_done.
    task automatic run_sweep(input int rdy_delay, input int max_stall,
                             input bit poke, output int done_at, output int nspk);
        int k, cnt_exp, bp, stall_left, hs_k;
        bit got_done;
        k = 0; cnt_exp = 0; bp = 0; stall_left = max_stall; hs_k = -1;
        got_done = 1'b0; done_at = -1; nspk = 0;
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        k = 1;
        chk("busy_after_start", int'(busy), 1);
        while (!got_done && k < 400) begin
            step_start = (poke && k == 4) ? 1'b1 : 1'b0;
            if (step_done) begin
                got_done = 1'b1;
                done_at = k;
                chk("neurons_served", cnt_exp, N);
                if (hs_k >= 0) chk("resume_after_hs", k, hs_k + 2);
            end
            if (in_req) begin
                if (hs_k >= 0) begin
                    chk("resume_after_hs", k, hs_k + 2);
                    hs_k = -1;
                end
                if (stall_left > 0) begin
                    in_valid = 1'b0;
                    stall_left--;
                end else begin
                    chk("in_idx", int'(in_idx), cnt_exp);
                    in_valid = 1'b1;
                    in_data = 9'(bench_data[cnt_exp]);
                    model_update(cnt_exp, bench_data[cnt_exp]);
                    cnt_exp++;
                    stall_left = max_stall;
                end
            end else begin
                // Junk on the request channel while not requesting must be ignored.
                in_valid = 1'b1;
                in_data = 9'h1FF;
            end
            if (spk_valid) begin
                if (spk_q.size() == 0) begin
                    chk("spk_unexpected", int'(spk_idx), -1);
                    spk_ready = 1'b1;
                end else begin
                    chk("spk_idx", int'(spk_idx), spk_q[0]);
                    if (bp < rdy_delay) begin
                        chk("in_req_during_bp", int'(in_req), 0);
                        spk_ready = 1'b0;
                        bp++;
                    end else begin
                        spk_ready = 1'b1;
                        void'(spk_q.pop_front());
                        nspk++;
                        bp = 0;
                        hs_k = k;
                    end
                end
            end else begin
                spk_ready = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0; spk_ready = 1'b0; step_start = 1'b0;
        if (!got_done) chk("sweep_timeout", 0, 1);
        chk("step_done_one_cycle", int'(step_done), 0);
        chk("busy_after_done", int'(busy), 0);
        chk("spk_q_empty", spk_q.size(), 0);
    endtask

    initial begin
        int done_at, nspk, seen_done;
        rst = 1'b0; step_start = 1'b0; in_valid = 1'b0; in_data = 9'd0;
        spk_ready = 1'b0; dbg_idx = '0;
        Vpde_thres = 8'd0; Vthres = 8'd0; Vrest = 8'd0; Vreset = 8'd0;
        a = 3'd0; b = 3'd0;

        //             vrst vpde vthr vrst  a  b  I    rdy mem  spk
        vecs[0] = '{   10, 100,   0,  20,  1, 0,   5,  0,  25, 0};
        vecs[1] = '{  250, 200, 240,   0,  0, 1,   1,  5, 250, N};
        vecs[2] = '{   50,  50,   0,  60,  2, 0,   0,  0,  70, 0};
        vecs[3] = '{   50,  49,  40,   0,  0, 3,   0,  0,  80, 0};
        vecs[4] = '{   30, 100,   0,  10,  7, 0, 300,  0, 190, 0};
        vecs[5] = '{  200, 220,   0, 250,  2, 0,  10,  1, 200, N};

        // Reset state.
        do_reset(10);
        chk("reset_busy", int'(busy), 0);
        chk("reset_spk_valid", int'(spk_valid), 0);
        chk("reset_in_req", int'(in_req), 0);
        chk("reset_step_done", int'(step_done), 0);
        chk("reset_in_idx", int'(in_idx), 0);
        chk("reset_spk_idx", int'(spk_idx), 0);
        for (int i = 0; i < N; i++) begin
            dbg_idx = IW'(i);
            #1;
            chk("reset_mem", int'(dbg_mem), 10);
        end

        // Table-driven single sweeps.
        for (int v = 0; v < 6; v++) begin
            Vpde_thres = 8'(vecs[v].vpde); Vthres = 8'(vecs[v].vthres);
            Vrest = 8'(vecs[v].vrest); a = 3'(vecs[v].ga); b = 3'(vecs[v].gb);
            do_reset(vecs[v].vreset);
            for (int i = 0; i < N; i++) bench_data[i] = vecs[v].idata;
            run_sweep(vecs[v].rdy_delay, 0, (v == 0), done_at, nspk);
            chk("spike_count", nspk, vecs[v].exp_spk);
            if (vecs[v].exp_spk == 0) chk("sweep_latency", done_at, 3 * N + 1);
            for (int i = 0; i < N; i++) begin
                dbg_idx = IW'(i);
                #1;
                chk("table_mem", int'(dbg_mem), vecs[v].exp_mem);
            end
        end

        // Two back-to-back sweeps with varied currents, input stalls and
        // spike backpressure; membranes carry over between sweeps.
        Vpde_thres = 8'd120; Vthres = 8'd90; Vrest = 8'd130; a = 3'd3; b = 3'd5;
        do_reset(100);
        for (int i = 0; i < N; i++) bench_data[i] = (i * 71 + 13) % 512;
        run_sweep(2, 1, 1'b0, done_at, nspk);
        check_mems("multi_mem1");
        for (int i = 0; i < N; i++) bench_data[i] = (i * 151 + 200) % 512;
        run_sweep(3, 2, 1'b0, done_at, nspk);
        check_mems("multi_mem2");

        // Reset mid-sweep: sweep abandoned, membranes back to Vreset, no step_done.
        Vpde_thres = 8'd100; Vrest = 8'd20; a = 3'd1;
        do_reset(10);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        in_valid = 1'b1; in_data = 9'd5;
        repeat (5) @(negedge clk);
        chk("midsweep_busy", int'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < N; i++) model_mem[i] = 10;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_req", int'(in_req), 0);
        chk("midrst_in_idx", int'(in_idx), 0);
        check_mems("midrst_mem");
        seen_done = 0;
        for (int i = 0; i < 3 * N + 4; i++) begin
            if (step_done) seen_done = 1;
            @(negedge clk);
        end
        chk("midrst_no_step_done", seen_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
